// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared types and constants for the Hi/Lo sequencer
package hilo_pkg;

   localparam int WORD_W       = 32;
   localparam int DIV_LAT_DEF  = 33;
   localparam int MULT_LAT_DEF = 33;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START_M = 3'd1,
      START_D = 3'd2,
      RUN_M   = 3'd3,
      RUN_D   = 3'd4,
      WRITE_M = 3'd5,
      WRITE_D = 3'd6,
      EXC     = 3'd7
   } state_t;

endpackage

// File: rtl/hilo_sequencer_lat_counter.sv
// rtl/hilo_sequencer_lat_counter.sv - loadable down-counter with zero flag
module lat_counter #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count;

   // Saturates at zero so a unit left idle in RUN can never wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/hilo_sequencer.sv
// rtl/hilo_sequencer.sv - MULT/DIV sequencing and Hi/Lo registers; DIVZERO_TRAP_EN enables the divide-by-zero trap
module hilo_sequencer
   import hilo_pkg::*;
#(
   parameter int DIV_LAT  = DIV_LAT_DEF,
   parameter int MULT_LAT = MULT_LAT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              op_mult,
   input  logic              op_div,
   input  logic              mthi,
   input  logic              mtlo,
   input  logic [WORD_W-1:0] wdata,
   input  logic              div_zero_in,
   input  logic [WORD_W-1:0] mult_hi,
   input  logic [WORD_W-1:0] mult_lo,
   input  logic [WORD_W-1:0] div_hi,
   input  logic [WORD_W-1:0] div_lo,
   output logic              mult_start,
   output logic              div_start,
   output logic              busy,
   output logic              done,
   output logic              div_zero_exc,
   output logic [WORD_W-1:0] hi,
   output logic [WORD_W-1:0] lo
);

   localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   state_t             state;
   state_t             next_state;
   logic               cnt_load;
   logic               cnt_en;
   logic               cnt_zero;
   logic [CNT_W-1:0]   cnt_val;

   // Loading as START is entered and counting through START lines the
   // capture edge up with the unit's result becoming stable.
   assign cnt_load = (state == IDLE) && (op_mult || op_div);
   assign cnt_val  = op_mult ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
   assign cnt_en   = (state == START_M) || (state == START_D) ||
                     (state == RUN_M)   || (state == RUN_D);

   lat_counter #(.W(CNT_W)) u_lat_counter (
      .clk      (clk),
      .rst      (reset),
      .load     (cnt_load),
      .en       (cnt_en),
      .load_val (cnt_val),
      .zero     (cnt_zero)
   );

`ifndef DIVZERO_TRAP_EN
   logic unused_div_zero;
   assign unused_div_zero = div_zero_in;
`endif

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (op_mult) begin
               next_state = START_M;
            end else if (op_div) begin
               next_state = START_D;
            end
         end
         START_M: next_state = RUN_M;
`ifdef DIVZERO_TRAP_EN
         START_D: next_state = div_zero_in ? EXC : RUN_D;
`else
         START_D: next_state = RUN_D;
`endif
         RUN_M:   if (cnt_zero) next_state = WRITE_M;
         RUN_D:   if (cnt_zero) next_state = WRITE_D;
         WRITE_M: next_state = IDLE;
         WRITE_D: next_state = IDLE;
         EXC:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         mult_start   <= 1'b0;
         div_start    <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         div_zero_exc <= 1'b0;
         hi           <= '0;
         lo           <= '0;
      end else begin
         state      <= next_state;
         mult_start <= (next_state == START_M);
         div_start  <= (next_state == START_D);
         busy       <= (next_state != IDLE);
         done       <= (state == WRITE_M) || (state == WRITE_D);
`ifdef DIVZERO_TRAP_EN
         div_zero_exc <= (state == EXC);
`else
         div_zero_exc <= 1'b0;
`endif
         // Register writes are only honoured in IDLE; WRITE owns hi/lo.
         case (state)
            IDLE: begin
               if (mthi) hi <= wdata;
               if (mtlo) lo <= wdata;
            end
            WRITE_M: begin
               hi <= mult_hi;
               lo <= mult_lo;
            end
            WRITE_D: begin
               hi <= div_hi;
               lo <= div_lo;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_sequencer.sv
// tb/tb_hilo_sequencer.sv - self-checking bench for hilo_sequencer
module tb_hilo_sequencer;

   localparam int LAT = 33;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_mult, op_div, mthi, mtlo;
   logic [31:0] wdata;
   logic        div_zero_in;
   logic [31:0] mult_hi = '0, mult_lo = '0, div_hi = '0, div_lo = '0;
   logic        mult_start, div_start, busy, done, div_zero_exc;
   logic [31:0] hi, lo;

   logic [31:0] opa = '0, opb = 32'd1;
   logic [31:0] mhi, mlo;
   int          checks = 0, errors = 0;
   int          n_mstart = 0, n_dstart = 0, n_done = 0, n_exc = 0;

   typedef struct {
      bit          m;
      bit          d;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] ehi;
      logic [31:0] elo;
   } vec_t;

   hilo_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .op_mult      (op_mult),
      .op_div       (op_div),
      .mthi         (mthi),
      .mtlo         (mtlo),
      .wdata        (wdata),
      .div_zero_in  (div_zero_in),
      .mult_hi      (mult_hi),
      .mult_lo      (mult_lo),
      .div_hi       (div_hi),
      .div_lo       (div_lo),
      .mult_start   (mult_start),
      .div_start    (div_start),
      .busy         (busy),
      .done         (done),
      .div_zero_exc (div_zero_exc),
      .hi           (hi),
      .lo           (lo)
   );

   always #5 clk = ~clk;

   assign div_zero_in = (opb == 32'd0);

   function automatic logic [63:0] expect_res(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa, sb;
      logic signed [63:0] p;
      sa = a;
      sb = b;
      if (is_mult) begin
         p = 64'(sa) * 64'(sb);
         return p;
      end
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      return {32'(sa % sb), 32'(sa / sb)};
   endfunction

   // Behavioural units: junk until LAT edges after the start edge, then the result.
   int          m_cnt = 0, d_cnt = 0;
   logic [63:0] m_res = '0, d_res = '0;
   always @(posedge clk) begin
      if (mult_start) begin
         m_cnt   <= LAT;
         m_res   <= expect_res(1'b1, opa, opb);
         mult_hi <= $urandom;
         mult_lo <= $urandom;
      end else if (m_cnt != 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) {mult_hi, mult_lo} <= m_res;
      end
      if (div_start) begin
         d_cnt  <= LAT;
         d_res  <= expect_res(1'b0, opa, opb);
         div_hi <= $urandom;
         div_lo <= $urandom;
      end else if (d_cnt != 0) begin
         d_cnt <= d_cnt - 1;
         if (d_cnt == 1) {div_hi, div_lo} <= d_res;
      end
   end

   always @(negedge clk) begin
      if (mult_start)   n_mstart++;
      if (div_start)    n_dstart++;
      if (done)         n_done++;
      if (div_zero_exc) n_exc++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic wait_done(output int edges);
      edges = 0;
      while (!done && edges < 200) begin
         step();
         edges++;
      end
   endtask

   task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                         input bit wr_hi, input logic [31:0] wv, input logic [63:0] res);
      int edges, ms0, ds0;
      ms0 = n_mstart;
      ds0 = n_dstart;
      opa = a;
      opb = b;
      op_mult = m;
      op_div = d;
      mthi = wr_hi;
      wdata = wv;
      step();
      op_mult = 1'b0;
      op_div = 1'b0;
      mthi = 1'b0;
      chk("busy_after_issue", 32'(busy), 32'd1);
      chk("mult_start_pulse", 32'(mult_start), 32'(m));
      chk("div_start_pulse", 32'(div_start), 32'(d && !m));
      if (wr_hi) begin
         mhi = wv;
         chk("mthi_with_op", hi, mhi);
      end
      wait_done(edges);
      chk("done_latency", 32'(edges), 32'(LAT + 2));
      mhi = res[63:32];
      mlo = res[31:0];
      chk("hi_result", hi, mhi);
      chk("lo_result", lo, mlo);
      chk("busy_with_done", 32'(busy), 32'd0);
      step();
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("mult_start_count", 32'(n_mstart - ms0), 32'(m));
      chk("div_start_count", 32'(n_dstart - ds0), 32'(d && !m));
   endtask

   initial begin
      vec_t vecs[5];
      int   edges, d0, e0;
      logic [31:0] a, b, w;

      vecs[0] = '{m: 1'b0, d: 1'b1, a: 32'd100, b: 32'd7, ehi: 32'd2, elo: 32'd14};
      vecs[1] = '{m: 1'b1, d: 1'b0, a: 32'd3, b: 32'hFFFF_FFFC, ehi: 32'hFFFF_FFFF, elo: 32'hFFFF_FFF4};
      vecs[2] = '{m: 1'b1, d: 1'b1, a: 32'd5, b: 32'd6, ehi: 32'd0, elo: 32'd30};
      vecs[3] = '{m: 1'b0, d: 1'b1, a: 32'hFFFF_FFF9, b: 32'd2, ehi: 32'hFFFF_FFFF, elo: 32'hFFFF_FFFD};
      vecs[4] = '{m: 1'b1, d: 1'b0, a: 32'h0001_0000, b: 32'h0001_0000, ehi: 32'd1, elo: 32'd0};

      // Reset with op_div pending
      reset = 1'b1;
      op_mult = 1'b0;
      op_div = 1'b1;
      mthi = 1'b0;
      mtlo = 1'b0;
      wdata = '0;
      #2;
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      chk("reset_flags", {27'd0, mult_start, div_start, busy, done, div_zero_exc}, 32'd0);
      step();
      step();
      step();
      chk("reset_no_div_start", 32'(n_dstart), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      op_div = 1'b0;
      reset = 1'b0;
      mhi = '0;
      mlo = '0;
      step();

      for (int i = 0; i < 5; i++) begin
         run_op(vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b, 1'b0, '0, {vecs[i].ehi, vecs[i].elo});
      end

      // mthi in IDLE
      mthi = 1'b1;
      wdata = 32'hDEAD_BEEF;
      step();
      mthi = 1'b0;
      mhi = 32'hDEAD_BEEF;
      chk("mthi_idle", hi, mhi);
      chk("mthi_lo_kept", lo, mlo);

      // mtlo while busy is ignored
      opa = 32'd100;
      opb = 32'd7;
      op_div = 1'b1;
      step();
      op_div = 1'b0;
      step();
      step();
      mtlo = 1'b1;
      wdata = 32'h1234_5678;
      step();
      mtlo = 1'b0;
      chk("mtlo_busy_ignored", lo, mlo);
      wait_done(edges);
      chk("mtlo_busy_done_seen", 32'(done), 32'd1);
      mhi = 32'd2;
      mlo = 32'd14;
      chk("mtlo_busy_lo_result", lo, mlo);
      step();

      // Divide by zero
      d0 = n_done;
      e0 = n_exc;
      opa = 32'd55;
      opb = 32'd0;
      op_div = 1'b1;
      step();
      op_div = 1'b0;
`ifdef DIVZERO_TRAP_EN
      edges = 0;
      while (!div_zero_exc && edges < 50) begin
         step();
         edges++;
      end
      chk("exc_latency", 32'(edges), 32'd2);
      chk("exc_busy", 32'(busy), 32'd0);
      step();
      chk("exc_one_cycle", 32'(div_zero_exc), 32'd0);
      for (int i = 0; i < 40; i++) step();
      chk("exc_no_done", 32'(n_done - d0), 32'd0);
      chk("exc_hi_kept", hi, mhi);
      chk("exc_lo_kept", lo, mlo);
      chk("exc_count", 32'(n_exc - e0), 32'd1);
`else
      wait_done(edges);
      chk("divzero_latency", 32'(edges), 32'(LAT + 2));
      mhi = 32'd55;
      mlo = 32'hFFFF_FFFF;
      chk("divzero_hi", hi, mhi);
      chk("divzero_lo", lo, mlo);
      step();
      chk("divzero_no_exc", 32'(n_exc - e0), 32'd0);
`endif
      opb = 32'd1;

      // Randomized operations against the reference
      for (int i = 0; i < 24; i++) begin
         int kind;
         kind = $urandom_range(0, 3);
         a = $urandom;
         b = $urandom;
         w = $urandom;
         if (b == 32'd0 || b == 32'hFFFF_FFFF) b = 32'd3;
         case (kind)
            0: run_op(1'b1, 1'b0, a, b, 1'b0, '0, expect_res(1'b1, a, b));
            1: run_op(1'b0, 1'b1, a, b, 1'b0, '0, expect_res(1'b0, a, b));
            2: begin
               mthi = 1'b1;
               mtlo = 1'b1;
               wdata = w;
               step();
               mthi = 1'b0;
               mtlo = 1'b0;
               mhi = w;
               mlo = w;
               chk("rand_mthi", hi, mhi);
               chk("rand_mtlo", lo, mlo);
            end
            default: run_op(1'b1, 1'b0, a, b, 1'b1, w, expect_res(1'b1, a, b));
         endcase
      end

      // Reset mid-RUN
      d0 = n_done;
      opa = 32'd9;
      opb = 32'd9;
      op_mult = 1'b1;
      step();
      op_mult = 1'b0;
      for (int i = 0; i < 10; i++) step();
      reset = 1'b1;
      #1;
      chk("midrun_hi", hi, 32'd0);
      chk("midrun_lo", lo, 32'd0);
      chk("midrun_busy", 32'(busy), 32'd0);
      step();
      step();
      reset = 1'b0;
      for (int i = 0; i < 45; i++) step();
      chk("midrun_no_done", 32'(n_done - d0), 32'd0);
      chk("midrun_hi_after", hi, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
